// File: rtl/uart_rx_bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_bram_writer
// Purpose  : UART receive channel. Deserialises i_RXD, decodes packets of the
//            form [opcode][length][payload...], packs payload bytes into
//            16-bit words written to a BRAM write port, then writes a header
//            word {opcode,length} at BASE_ADDR. Counts opcode, size/timeout
//            and stop-bit errors with saturating 8-bit counters.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_RXD               - serial line, idle high, asynchronous
//            i_Period_Num        - clk cycles per bit, latched at each start bit
//            i_RX_MEM_RST        - clears done/len/counters, restarts packet FSM
//            o_BRAM_EN/WE/Addr/Din - BRAM write port (one-cycle strobes)
//            o_RX_Done, o_RX_Len - last good packet status
//            o_OPCode_ERR, o_Data_Size_ERR, o_Frame_ERR - error counters
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_bram_writer #(
    parameter int                   MSB_FIRST_MODE = 0,
    parameter int                   ADDR_SIZE      = 16,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]           OPCODE         = 8'hA5,
    parameter int                   MAX_BYTES      = 64,
    parameter int                   TIMEOUT_BITS   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_RXD,
    input  logic [31:0]          i_Period_Num,
    input  logic                 i_RX_MEM_RST,
    output logic                 o_BRAM_EN,
    output logic [1:0]           o_BRAM_WE,
    output logic [ADDR_SIZE-1:0] o_BRAM_Addr,
    output logic [15:0]          o_BRAM_Din,
    output logic                 o_RX_Done,
    output logic [7:0]           o_RX_Len,
    output logic [7:0]           o_OPCode_ERR,
    output logic [7:0]           o_Data_Size_ERR,
    output logic [7:0]           o_Frame_ERR
);

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_e;

    typedef enum logic [1:0] {
        P_OP   = 2'd0,
        P_LEN  = 2'd1,
        P_DATA = 2'd2,
        P_HDR  = 2'd3
    } pkt_state_e;

    localparam logic [7:0]  c_MAX_LEN      = 8'(MAX_BYTES);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_BITS - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 r_sync1_q, r_sync2_q, r_rxd_prev_q;
    bit_state_e           r_bit_state_q, r_bit_state_d;
    logic [31:0]          r_period_q, r_period_d;
    logic [31:0]          r_cnt_q, r_cnt_d;
    logic [2:0]           r_bit_idx_q, r_bit_idx_d;
    logic [7:0]           r_shift_q, r_shift_d;

    pkt_state_e           r_pkt_state_q, r_pkt_state_d;
    logic [7:0]           r_len_q, r_len_d;
    logic [7:0]           r_idx_q, r_idx_d;
    logic [7:0]           r_lo_q, r_lo_d;
    logic [31:0]          r_idle_cyc_q, r_idle_cyc_d;
    logic [31:0]          r_idle_bits_q, r_idle_bits_d;

    logic                 r_bram_en_q, r_bram_en_d;
    logic [ADDR_SIZE-1:0] r_bram_addr_q, r_bram_addr_d;
    logic [15:0]          r_bram_din_q, r_bram_din_d;
    logic                 r_done_q, r_done_d;
    logic [7:0]           r_rx_len_q, r_rx_len_d;
    logic [7:0]           r_op_err_q, r_op_err_d;
    logic [7:0]           r_size_err_q, r_size_err_d;
    logic [7:0]           r_frame_err_q, r_frame_err_d;

    logic                 w_rxd;
    logic                 w_fall;
    logic                 w_byte_vld;
    logic                 w_stop_err;
    logic                 w_timeout;
    logic                 w_last;
    logic [ADDR_SIZE-1:0] w_pay_addr;

    // All line decisions use the second synchroniser stage; the extra
    // delayed copy gives a glitch-free falling-edge detector.
    assign w_rxd  = r_sync2_q;
    assign w_fall = r_rxd_prev_q & ~r_sync2_q;

    // Word k of the payload lives one above the header word.
    assign w_pay_addr = BASE_ADDR + ADDR_SIZE'(1) + ADDR_SIZE'(r_idx_q[7:1]);
    assign w_last     = (r_idx_q == (r_len_q - 8'd1));

    // ------------------------------------------------------------------
    // Bit-level receiver
    // ------------------------------------------------------------------
    always_comb begin
        r_bit_state_d = r_bit_state_q;
        r_period_d    = r_period_q;
        r_cnt_d       = r_cnt_q;
        r_bit_idx_d   = r_bit_idx_q;
        r_shift_d     = r_shift_q;
        w_byte_vld    = 1'b0;
        w_stop_err    = 1'b0;

        case (r_bit_state_q)
            BIT_IDLE: begin
                if (w_fall) begin
                    r_period_d    = i_Period_Num;
                    r_cnt_d       = 32'd0;
                    r_bit_state_d = BIT_START;
                end
            end
            BIT_START: begin
                if (r_cnt_q == (r_period_q >> 1)) begin
                    // Line back high at mid-start means a glitch: drop it.
                    r_cnt_d       = 32'd0;
                    r_bit_idx_d   = 3'd0;
                    r_bit_state_d = w_rxd ? BIT_IDLE : BIT_DATA;
                end else begin
                    r_cnt_d = r_cnt_q + 32'd1;
                end
            end
            BIT_DATA: begin
                if (r_cnt_q == (r_period_q - 32'd1)) begin
                    r_cnt_d     = 32'd0;
                    r_bit_idx_d = r_bit_idx_q + 3'd1;
                    if (MSB_FIRST_MODE != 0) begin
                        r_shift_d = {r_shift_q[6:0], w_rxd};
                    end else begin
                        r_shift_d = {w_rxd, r_shift_q[7:1]};
                    end
                    if (r_bit_idx_q == 3'd7) begin
                        r_bit_state_d = BIT_STOP;
                    end
                end else begin
                    r_cnt_d = r_cnt_q + 32'd1;
                end
            end
            BIT_STOP: begin
                if (r_cnt_q == (r_period_q - 32'd1)) begin
                    r_cnt_d       = 32'd0;
                    w_byte_vld    = w_rxd;
                    w_stop_err    = ~w_rxd;
                    r_bit_state_d = BIT_IDLE;
                end else begin
                    r_cnt_d = r_cnt_q + 32'd1;
                end
            end
            default: r_bit_state_d = BIT_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Packet decoder, BRAM write generation and error counters
    // ------------------------------------------------------------------
    always_comb begin
        r_pkt_state_d = r_pkt_state_q;
        r_len_d       = r_len_q;
        r_idx_d       = r_idx_q;
        r_lo_d        = r_lo_q;
        r_idle_cyc_d  = 32'd0;
        r_idle_bits_d = 32'd0;
        r_bram_en_d   = 1'b0;
        r_bram_addr_d = r_bram_addr_q;
        r_bram_din_d  = r_bram_din_q;
        r_done_d      = r_done_q;
        r_rx_len_d    = r_rx_len_q;
        r_op_err_d    = r_op_err_q;
        r_size_err_d  = r_size_err_q;
        r_frame_err_d = r_frame_err_q;
        w_timeout     = 1'b0;

        // Inter-byte timeout: counted in whole bit periods while the line
        // is idle inside a packet, so no multiplier is needed.
        if (((r_pkt_state_q == P_LEN) || (r_pkt_state_q == P_DATA)) &&
            (r_bit_state_q == BIT_IDLE)) begin
            if (r_idle_cyc_q == (r_period_q - 32'd1)) begin
                if (r_idle_bits_q == c_TIMEOUT_LAST) begin
                    w_timeout = 1'b1;
                end else begin
                    r_idle_bits_d = r_idle_bits_q + 32'd1;
                end
            end else begin
                r_idle_cyc_d  = r_idle_cyc_q + 32'd1;
                r_idle_bits_d = r_idle_bits_q;
            end
        end

        case (r_pkt_state_q)
            P_OP: begin
                if (w_byte_vld) begin
                    if (r_shift_q == OPCODE) begin
                        r_pkt_state_d = P_LEN;
                    end else begin
                        r_op_err_d = sat_inc(r_op_err_q);
                    end
                end
            end
            P_LEN: begin
                if (w_byte_vld) begin
                    if ((r_shift_q == 8'd0) || (r_shift_q > c_MAX_LEN)) begin
                        r_size_err_d  = sat_inc(r_size_err_q);
                        r_pkt_state_d = P_OP;
                    end else begin
                        r_len_d       = r_shift_q;
                        r_idx_d       = 8'd0;
                        r_pkt_state_d = P_DATA;
                    end
                end
            end
            P_DATA: begin
                if (w_byte_vld) begin
                    r_idx_d = r_idx_q + 8'd1;
                    if (!r_idx_q[0]) begin
                        r_lo_d = r_shift_q;
                        if (w_last) begin
                            // Odd length: flush the half word with a zero top byte.
                            r_bram_en_d   = 1'b1;
                            r_bram_addr_d = w_pay_addr;
                            r_bram_din_d  = {8'h00, r_shift_q};
                            r_pkt_state_d = P_HDR;
                        end
                    end else begin
                        r_bram_en_d   = 1'b1;
                        r_bram_addr_d = w_pay_addr;
                        r_bram_din_d  = {r_shift_q, r_lo_q};
                        if (w_last) begin
                            r_pkt_state_d = P_HDR;
                        end
                    end
                end
            end
            P_HDR: begin
                r_bram_en_d   = 1'b1;
                r_bram_addr_d = BASE_ADDR;
                r_bram_din_d  = {OPCODE, r_len_q};
                r_done_d      = 1'b1;
                r_rx_len_d    = r_len_q;
                r_pkt_state_d = P_OP;
            end
            default: r_pkt_state_d = P_OP;
        endcase

        // A bad stop bit drops the byte and abandons any packet in progress.
        if (w_stop_err) begin
            r_frame_err_d = sat_inc(r_frame_err_q);
            if ((r_pkt_state_q == P_LEN) || (r_pkt_state_q == P_DATA)) begin
                r_pkt_state_d = P_OP;
            end
        end

        if (w_timeout) begin
            r_size_err_d  = sat_inc(r_size_err_q);
            r_pkt_state_d = P_OP;
            r_idle_cyc_d  = 32'd0;
            r_idle_bits_d = 32'd0;
        end

        // Memory-side clear wins over any same-cycle update; the bit
        // receiver keeps running so a byte in flight is not corrupted.
        if (i_RX_MEM_RST) begin
            r_pkt_state_d = P_OP;
            r_idx_d       = 8'd0;
            r_bram_en_d   = 1'b0;
            r_done_d      = 1'b0;
            r_rx_len_d    = 8'd0;
            r_op_err_d    = 8'd0;
            r_size_err_d  = 8'd0;
            r_frame_err_d = 8'd0;
            r_idle_cyc_d  = 32'd0;
            r_idle_bits_d = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q     <= 1'b1;
            r_sync2_q     <= 1'b1;
            r_rxd_prev_q  <= 1'b1;
            r_bit_state_q <= BIT_IDLE;
            r_period_q    <= 32'd0;
            r_cnt_q       <= 32'd0;
            r_bit_idx_q   <= 3'd0;
            r_shift_q     <= 8'd0;
            r_pkt_state_q <= P_OP;
            r_len_q       <= 8'd0;
            r_idx_q       <= 8'd0;
            r_lo_q        <= 8'd0;
            r_idle_cyc_q  <= 32'd0;
            r_idle_bits_q <= 32'd0;
            r_bram_en_q   <= 1'b0;
            r_bram_addr_q <= '0;
            r_bram_din_q  <= 16'd0;
            r_done_q      <= 1'b0;
            r_rx_len_q    <= 8'd0;
            r_op_err_q    <= 8'd0;
            r_size_err_q  <= 8'd0;
            r_frame_err_q <= 8'd0;
        end else begin
            r_sync1_q     <= i_RXD;
            r_sync2_q     <= r_sync1_q;
            r_rxd_prev_q  <= r_sync2_q;
            r_bit_state_q <= r_bit_state_d;
            r_period_q    <= r_period_d;
            r_cnt_q       <= r_cnt_d;
            r_bit_idx_q   <= r_bit_idx_d;
            r_shift_q     <= r_shift_d;
            r_pkt_state_q <= r_pkt_state_d;
            r_len_q       <= r_len_d;
            r_idx_q       <= r_idx_d;
            r_lo_q        <= r_lo_d;
            r_idle_cyc_q  <= r_idle_cyc_d;
            r_idle_bits_q <= r_idle_bits_d;
            r_bram_en_q   <= r_bram_en_d;
            r_bram_addr_q <= r_bram_addr_d;
            r_bram_din_q  <= r_bram_din_d;
            r_done_q      <= r_done_d;
            r_rx_len_q    <= r_rx_len_d;
            r_op_err_q    <= r_op_err_d;
            r_size_err_q  <= r_size_err_d;
            r_frame_err_q <= r_frame_err_d;
        end
    end

    assign o_BRAM_EN       = r_bram_en_q;
    assign o_BRAM_WE       = {2{r_bram_en_q}};
    assign o_BRAM_Addr     = r_bram_addr_q;
    assign o_BRAM_Din      = r_bram_din_q;
    assign o_RX_Done       = r_done_q;
    assign o_RX_Len        = r_rx_len_q;
    assign o_OPCode_ERR    = r_op_err_q;
    assign o_Data_Size_ERR = r_size_err_q;
    assign o_Frame_ERR     = r_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_bram_writer
// Purpose  : Self-checking bench. Two receivers (LSB-first and MSB-first) are
//            fed the same byte stream, each serialised in its own bit order,
//            and both are compared with a byte-level packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_bram_writer;

    localparam int         c_MAX  = 64;
    localparam logic [7:0] c_OP   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd_l, rxd_m;
    logic [31:0] period;
    logic        mem_rst_i;

    logic        en_l, en_m, done_l, done_m;
    logic [1:0]  we_l, we_m;
    logic [15:0] addr_l, addr_m, din_l, din_m;
    logic [7:0]  len_l, len_m, op_l, op_m, sz_l, sz_m, fr_l, fr_m;

    always #5 clk = ~clk;

    uart_rx_bram_writer #(.MSB_FIRST_MODE(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .i_RXD(rxd_l), .i_Period_Num(period),
        .i_RX_MEM_RST(mem_rst_i), .o_BRAM_EN(en_l), .o_BRAM_WE(we_l),
        .o_BRAM_Addr(addr_l), .o_BRAM_Din(din_l), .o_RX_Done(done_l),
        .o_RX_Len(len_l), .o_OPCode_ERR(op_l), .o_Data_Size_ERR(sz_l),
        .o_Frame_ERR(fr_l));

    uart_rx_bram_writer #(.MSB_FIRST_MODE(1)) u_dut_msb (
        .clk(clk), .rst(rst), .i_RXD(rxd_m), .i_Period_Num(period),
        .i_RX_MEM_RST(mem_rst_i), .o_BRAM_EN(en_m), .o_BRAM_WE(we_m),
        .o_BRAM_Addr(addr_m), .o_BRAM_Din(din_m), .o_RX_Done(done_m),
        .o_RX_Len(len_m), .o_OPCode_ERR(op_m), .o_Data_Size_ERR(sz_m),
        .o_Frame_ERR(fr_m));

    // ---------------- write capture (sampled on the falling edge) -------
    logic [15:0] mem_l[int], mem_m[int];
    int          wr_l = 0, wr_m = 0, we_bad = 0, cyc = 0;
    int          wc_l[$], wa_l[$];

    always @(negedge clk) begin
        cyc++;
        if (we_l !== {2{en_l}}) we_bad++;
        if (we_m !== {2{en_m}}) we_bad++;
        if (en_l === 1'b1) begin
            mem_l[int'(addr_l)] = din_l;
            wr_l++;
            wc_l.push_back(cyc);
            wa_l.push_back(int'(addr_l));
        end
        if (en_m === 1'b1) begin
            mem_m[int'(addr_m)] = din_m;
            wr_m++;
        end
    end

    function automatic logic [15:0] get_l(input int a);
        return mem_l.exists(a) ? mem_l[a] : 16'hDEAD;
    endfunction
    function automatic logic [15:0] get_m(input int a);
        return mem_m.exists(a) ? mem_m[a] : 16'hDEAD;
    endfunction

    // ---------------- checking ------------------------------------------
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural packet model --------------------------
    // Works on whole bytes: collects the payload and derives the stored
    // words from it when the packet completes or is abandoned.
    int          m_mode;       // 0 expect opcode, 1 expect length, 2 payload
    int          m_len;
    logic [7:0]  m_pay[$];
    logic [15:0] m_mem[int];
    int          m_writes;
    logic        m_done;
    logic [7:0]  m_rxlen, m_op, m_sz, m_fr;
    int          wr_base_l = 0, wr_base_m = 0;

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic model_write(input int a, input logic [15:0] d);
        m_mem[a] = d;
        m_writes++;
    endtask

    task automatic model_words(input bit with_tail);
        int n;
        n = m_pay.size();
        for (int k = 0; k < n / 2; k++) model_write(1 + k, {m_pay[2*k+1], m_pay[2*k]});
        if (with_tail && (n % 2 == 1)) model_write(1 + n / 2, {8'h00, m_pay[n-1]});
    endtask

    task automatic model_abort();
        if (m_mode == 2) model_words(1'b0);
        m_mode = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            0: if (b == c_OP) m_mode = 1; else m_op = sat8(m_op);
            1: if (b == 8'd0 || int'(b) > c_MAX) begin
                   m_sz = sat8(m_sz); m_mode = 0;
               end else begin
                   m_len = int'(b); m_pay.delete(); m_mode = 2;
               end
            default: begin
                m_pay.push_back(b);
                if (m_pay.size() == m_len) begin
                    model_words(1'b1);
                    model_write(0, {c_OP, 8'(m_len)});
                    m_done = 1'b1; m_rxlen = 8'(m_len); m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic model_clear();
        m_mode = 0; m_done = 1'b0; m_rxlen = 8'd0;
        m_op = 8'd0; m_sz = 8'd0; m_fr = 8'd0;
        m_mem.delete(); m_writes = 0;
        wr_base_l = wr_l; wr_base_m = wr_m;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".done_l"}, 32'(done_l), 32'(m_done));
        chk({tag, ".done_m"}, 32'(done_m), 32'(m_done));
        chk({tag, ".len_l"},  32'(len_l),  32'(m_rxlen));
        chk({tag, ".len_m"},  32'(len_m),  32'(m_rxlen));
        chk({tag, ".op_l"},   32'(op_l),   32'(m_op));
        chk({tag, ".op_m"},   32'(op_m),   32'(m_op));
        chk({tag, ".sz_l"},   32'(sz_l),   32'(m_sz));
        chk({tag, ".sz_m"},   32'(sz_m),   32'(m_sz));
        chk({tag, ".fr_l"},   32'(fr_l),   32'(m_fr));
        chk({tag, ".fr_m"},   32'(fr_m),   32'(m_fr));
        chk({tag, ".writes_l"}, 32'(wr_l - wr_base_l), 32'(m_writes));
        chk({tag, ".writes_m"}, 32'(wr_m - wr_base_m), 32'(m_writes));
        foreach (m_mem[a]) begin
            chk($sformatf("%s.word_l[%0d]", tag, a), 32'(get_l(a)), 32'(m_mem[a]));
            chk($sformatf("%s.word_m[%0d]", tag, a), 32'(get_m(a)), 32'(m_mem[a]));
        end
    endtask

    // ---------------- stimulus ------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        rxd_l = 1'b0; rxd_m = 1'b0; wait_cyc(int'(period));
        for (int i = 0; i < 8; i++) begin
            rxd_l = b[i]; rxd_m = b[7-i]; wait_cyc(int'(period));
        end
        rxd_l = stop_ok; rxd_m = stop_ok; wait_cyc(int'(period));
        rxd_l = 1'b1; rxd_m = 1'b1; wait_cyc(gap_bits * int'(period));
    endtask

    task automatic tx(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        send_byte(b, stop_ok, gap_bits);
        if (stop_ok) model_byte(b);
        else begin
            m_fr = sat8(m_fr);
            if (m_mode != 0) model_abort();
        end
    endtask

    task automatic pulse_mem_rst();
        mem_rst_i = 1'b1; wait_cyc(1); mem_rst_i = 1'b0; wait_cyc(1);
        model_clear();
    endtask

    // ---------------- directed vectors ----------------------------------
    typedef struct {
        int              n;
        logic [5:0][7:0] b;      // b[0] is sent first
        int              nw;
        logic [2:0][15:0] w;     // w[k] expected at word address k
        int              wr;
        logic            done;
        logic [7:0]      len, op, sz;
    } vec_t;

    vec_t tab[4];

    initial begin
        repeat (95000) @(negedge clk);
        $display("FAIL watchdog: got cycle budget exhausted, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{n:6, b:48'h4433_2211_04A5, nw:3, w:48'h4433_2211_A504, wr:3,
                   done:1'b1, len:8'd4, op:8'd0, sz:8'd0};
        tab[1] = '{n:5, b:48'h0003_0201_03A5, nw:3, w:48'h0003_0201_A503, wr:3,
                   done:1'b1, len:8'd3, op:8'd0, sz:8'd0};
        tab[2] = '{n:4, b:48'h0000_7E01_A55A, nw:2, w:48'h0000_007E_A501, wr:2,
                   done:1'b1, len:8'd1, op:8'd1, sz:8'd0};
        tab[3] = '{n:4, b:48'h0000_41A5_00A5, nw:0, w:48'h0, wr:0,
                   done:1'b0, len:8'd0, op:8'd0, sz:8'd2};

        rst = 1'b1; rxd_l = 1'b1; rxd_m = 1'b1; mem_rst_i = 1'b0; period = 32'd54;
        model_clear();
        wait_cyc(4);
        chk("reset.en",   32'(en_l),   32'd0);
        chk("reset.we",   32'(we_l),   32'd0);
        chk("reset.addr", 32'(addr_l), 32'd0);
        chk("reset.din",  32'(din_l),  32'd0);
        chk("reset.done", 32'(done_l), 32'd0);
        chk("reset.cnts", {op_l, sz_l, fr_l, len_l}, 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        // Table-driven packets at P=54
        for (int r = 0; r < 4; r++) begin
            pulse_mem_rst();
            for (int i = 0; i < tab[r].n; i++) tx(tab[r].b[i], 1'b1, (i == tab[r].n - 1) ? 2 : 1);
            chk($sformatf("row%0d.writes_l", r), 32'(wr_l - wr_base_l), 32'(tab[r].wr));
            chk($sformatf("row%0d.writes_m", r), 32'(wr_m - wr_base_m), 32'(tab[r].wr));
            chk($sformatf("row%0d.done", r), 32'(done_l), 32'(tab[r].done));
            chk($sformatf("row%0d.len", r),  32'(len_l),  32'(tab[r].len));
            chk($sformatf("row%0d.op", r),   32'(op_l),   32'(tab[r].op));
            chk($sformatf("row%0d.sz", r),   32'(sz_l),   32'(tab[r].sz));
            for (int k = 0; k < tab[r].nw; k++) begin
                chk($sformatf("row%0d.w_l[%0d]", r, k), 32'(get_l(k)), 32'(tab[r].w[k]));
                chk($sformatf("row%0d.w_m[%0d]", r, k), 32'(get_m(k)), 32'(tab[r].w[k]));
            end
            if (tab[r].wr > 0) begin
                chk($sformatf("row%0d.hdr_addr", r), 32'(wa_l[$]), 32'd0);
                chk($sformatf("row%0d.hdr_adjacent", r), 32'(wc_l[$] - wc_l[$-1]), 32'd1);
            end
            check_model($sformatf("row%0d", r));
        end

        // One-cycle low glitch: nothing may change
        rxd_l = 1'b0; rxd_m = 1'b0; wait_cyc(1);
        rxd_l = 1'b1; rxd_m = 1'b1; wait_cyc(3 * int'(period));
        check_model("glitch");

        // Stop bit forced low: frame error, packet abandoned
        pulse_mem_rst();
        tx(8'hA5, 1'b1, 1); tx(8'h02, 1'b1, 1); tx(8'h11, 1'b1, 1);
        tx(8'h22, 1'b0, 2);
        chk("frame.fr", 32'(fr_l), 32'd1);
        chk("frame.writes", 32'(wr_l - wr_base_l), 32'd0);
        tx(8'h33, 1'b1, 2);   // now taken as an opcode
        check_model("frame");

        // Stall inside a packet: timeout, partial payload kept, no header
        pulse_mem_rst();
        tx(8'hA5, 1'b1, 1); tx(8'h08, 1'b1, 1); tx(8'h01, 1'b1, 1);
        tx(8'h02, 1'b1, 25);
        if (m_mode != 0) begin m_sz = sat8(m_sz); model_abort(); end
        chk("timeout.sz", 32'(sz_l), 32'd1);
        chk("timeout.writes", 32'(wr_l - wr_base_l), 32'd1);
        chk("timeout.word1", 32'(get_l(1)), 32'h0201);
        chk("timeout.done", 32'(done_l), 32'd0);
        check_model("timeout");
        pulse_mem_rst();
        chk("memrst.cnts", {op_l, sz_l, fr_l, len_l}, 32'd0);
        chk("memrst.done", 32'(done_l), 32'd0);

        // Synchronous reset in the middle of a frame
        tx(8'hA5, 1'b1, 1); tx(8'h01, 1'b1, 1); tx(8'h99, 1'b1, 2);
        chk("prerst.done", 32'(done_l), 32'd1);
        tx(8'h5A, 1'b1, 2);
        rxd_l = 1'b0; rxd_m = 1'b0; wait_cyc(3 * int'(period));
        rst = 1'b1; rxd_l = 1'b1; rxd_m = 1'b1; wait_cyc(2);
        rst = 1'b0; wait_cyc(1);
        chk("midrst.en",   32'(en_l),   32'd0);
        chk("midrst.done", 32'(done_l), 32'd0);
        chk("midrst.cnts", {op_l, sz_l, fr_l, len_l}, 32'd0);
        model_clear();
        wait_cyc(12 * int'(period));
        tx(8'hA5, 1'b1, 1); tx(8'h02, 1'b1, 1); tx(8'hAB, 1'b1, 1); tx(8'hCD, 1'b1, 2);
        check_model("postrst");

        // Randomised packets; new packets overwrite while Done stays set
        pulse_mem_rst();
        for (int pk = 0; pk < 10; pk++) begin
            int          kind, len;
            logic [7:0]  b;
            period = (pk == 0) ? 32'd5 : 32'($urandom_range(5, 12));
            kind   = $urandom_range(0, 9);
            if (kind == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == c_OP) b = 8'h5A;
                tx(b, 1'b1, 1);
            end
            tx(c_OP, 1'b1, 1);
            if (kind == 1) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(c_MAX + 1, 255);
                tx(8'(len), 1'b1, 2);
            end else begin
                len = (pk == 0) ? c_MAX : $urandom_range(1, 14);
                tx(8'(len), 1'b1, 1);
                for (int i = 0; i < len; i++)
                    tx(8'($urandom_range(0, 255)), 1'b1, (i == len - 1) ? 2 : 1);
            end
            check_model($sformatf("rand%0d", pk));
        end

        chk("we_follows_en", 32'(we_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
